// File: rtl/seg_pkg.sv
// Shared definitions for the chess-clock display stage: segment encodings,
// converter state and the BCD payload carried from converter to scanner.
package seg_pkg;

  // Segment bytes are {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [2:0] DP_BIT    = 3'd7;
  localparam logic [7:0] SEG_A     = 8'b1000_1000;
  localparam logic [7:0] SEG_B     = 8'b1000_0011;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  // d2 = tens of seconds, d1 = units of seconds, d0 = tenths
  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd3_t;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Timer-to-display bundle: quasi-static timer state in, multiplexed display drive out.
interface seg_scan_display_if #(
  parameter int unsigned CNT_W = 9
);
  logic [CNT_W-1:0] cnt_dis;
  logic             win;
  logic             seg_en;
  logic [7:0]       seg;
  logic [3:0]       an;

  modport master (output cnt_dis, win, seg_en, input seg, an);
  modport slave  (input cnt_dis, win, seg_en, output seg, an);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, results published together in DONE.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_c_o,
  output bcd3_t            bcd_o
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SH_W  = BCD_W + CNT_W;
  localparam int unsigned IT_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  conv_state_e      state_q, state_d;
  logic [SH_W-1:0]  shift_q, shift_d, dab;
  logic [IT_W-1:0]  it_q, it_d;
  bcd3_t            bcd_q, bcd_d;
  logic             busy_q, busy_d;

  // Add-3 correction on every BCD nibble that would overflow after the shift
  always_comb begin
    dab = shift_q;
    for (int k = 0; k < 3; k++) begin
      if (dab[CNT_W + 4*k +: 4] >= 4'd5) begin
        dab[CNT_W + 4*k +: 4] = dab[CNT_W + 4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    it_d    = it_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shift_d = {BCD_W'(0), bin_i};
          it_d    = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d = {dab[SH_W-2:0], 1'b0};
        it_d    = it_q + 1'b1;
        if (it_q == IT_W'(CNT_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = bcd3_t'(shift_q[SH_W-1 -: BCD_W]);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      it_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      it_q    <= it_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_c_o = (state_q == ST_DONE);
  assign bcd_o    = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Chess-clock display: filters and snapshots the timer count, converts it to
// BCD once per frame and scans "P SS.T" onto four multiplexed digits.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 125,
  parameter int unsigned CNT_W        = 9
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_s1_q, cnt_s2_q, cnt_prev_q, snap_cnt_q;
  logic             win_s1_q, win_s2_q, en_s1_q, en_s2_q;
  logic             snap_win_q, frozen_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic             conv_win_q, disp_win_q, disp_valid_q;
  logic [7:0]       seg_q, seg_d, digit_seg;
  logic [3:0]       an_q, an_d, digit_an;
  logic             div_wrap, frame_wrap, accept;
  logic             conv_busy, conv_done_c;
  bcd3_t            bcd;

  bin2bcd_seq #(.CNT_W(CNT_W)) u_b2b (
    .clk      (clk),
    .rst      (rst),
    .start_i  (frame_wrap),
    .bin_i    (snap_cnt_q),
    .busy_o   (conv_busy),
    .done_c_o (conv_done_c),
    .bcd_o    (bcd)
  );

  // A count is taken only after two equal synchronised samples, and never while timed out
  always_comb begin
    div_wrap   = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_wrap = div_wrap && (idx_q == 2'd3);
    accept     = (cnt_s2_q == cnt_prev_q) && !en_s2_q && !frozen_q;
  end

  always_comb begin
    div_d       = div_wrap ? '0 : div_q + 1'b1;
    idx_d       = div_wrap ? idx_q + 2'd1 : idx_q;
    blink_on_d  = blink_on_q;
    frame_cnt_d = frame_cnt_q;
    if (!frozen_q) begin
      blink_on_d  = 1'b1;
      frame_cnt_d = '0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    digit_seg = SEG_BLANK;
    digit_an  = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd3: digit_seg = disp_win_q ? SEG_B : SEG_A;
      2'd2: begin
        // Leading-zero tens digit is dark: pattern and enable both off
        if (bcd.d2 == 4'd0) digit_an  = 4'hF;
        else                digit_seg = seg_digit(bcd.d2);
      end
      2'd1: begin
        digit_seg         = seg_digit(bcd.d1);
        digit_seg[DP_BIT] = 1'b0;
      end
      default: digit_seg = seg_digit(bcd.d0);
    endcase

    // Drive changes only on slot boundaries so a digit never glitches mid-slot
    seg_d = seg_q;
    an_d  = an_q;
    if (div_wrap) begin
      if (!disp_valid_q) begin
        seg_d = SEG_BLANK;
        an_d  = 4'hF;
      end else begin
        seg_d = digit_seg;
        an_d  = blink_on_d ? digit_an : 4'hF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_s1_q     <= '0;
      cnt_s2_q     <= '0;
      cnt_prev_q   <= '0;
      win_s1_q     <= 1'b0;
      win_s2_q     <= 1'b0;
      en_s1_q      <= 1'b0;
      en_s2_q      <= 1'b0;
      snap_cnt_q   <= '0;
      snap_win_q   <= 1'b0;
      frozen_q     <= 1'b0;
      div_q        <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      conv_win_q   <= 1'b0;
      disp_win_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
    end else begin
      cnt_s1_q    <= bus.cnt_dis;
      cnt_s2_q    <= cnt_s1_q;
      cnt_prev_q  <= cnt_s2_q;
      win_s1_q    <= bus.win;
      win_s2_q    <= win_s1_q;
      en_s1_q     <= bus.seg_en;
      en_s2_q     <= en_s1_q;
      frozen_q    <= en_s2_q;
      if (accept) begin
        snap_cnt_q <= cnt_s2_q;
        snap_win_q <= win_s2_q;
      end
      div_q       <= div_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      // Player letter travels with the count it was snapshotted with
      if (frame_wrap && !conv_busy) conv_win_q <= snap_win_q;
      if (conv_done_c) begin
        disp_win_q   <= conv_win_q;
        disp_valid_q <= 1'b1;
      end
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a 4-cycle slot and 2-frame blink.
module tb_seg_scan_display;
  import seg_pkg::*;

  localparam int unsigned CNT_W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_display_if #(.CNT_W(CNT_W)) bus ();

  seg_scan_display #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_seg [4];
  int         cap_lit [4];
  int         cap_dark;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Poll until a given slot shows a given pattern, bounded by budget cycles
  task automatic wait_show(input int slot, input logic [7:0] exp, input int budget, output bit ok);
    logic [3:0] m;
    m  = ~(4'b0001 << slot);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.an == m && bus.seg == exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Record one frame (16 cycles) of display activity
  task automatic capture_frame();
    logic [3:0] m;
    cap_dark = 0;
    for (int j = 0; j < 4; j++) begin
      cap_lit[j] = 0;
      cap_seg[j] = 8'hFF;
    end
    repeat (16) begin
      @(negedge clk);
      if (bus.an == 4'hF) cap_dark++;
      for (int j = 0; j < 4; j++) begin
        m = ~(4'b0001 << j);
        if (bus.an == m) begin
          cap_lit[j]++;
          cap_seg[j] = bus.seg;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp [4];
    bit ok;
    exp = '{8'hC0, 8'h40, 8'hFF, 8'h88};
    rst = 1'b1;
    bus.cnt_dis = '0;
    bus.win = 1'b0;
    bus.seg_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL rst_an: got %h required %h", bus.an, 4'hF); end
    n_checks++;
    if (bus.seg !== 8'hFF) begin n_fail++; $display("FAIL rst_seg: got %h required %h", bus.seg, 8'hFF); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL rst_dark_before_done: got %h required %h", bus.an, 4'hF); end
    wait_show(3, 8'h88, 80, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_first_frame: got %0d required 1", ok); end
    capture_frame();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL rst_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
    end
    n_checks++;
    if (cap_lit[2] !== 0) begin n_fail++; $display("FAIL rst_no_digit2: got %0d required 0", cap_lit[2]); end
    n_checks++;
    if (cap_dark !== 4) begin n_fail++; $display("FAIL rst_dark_slot: got %0d required 4", cap_dark); end
  endtask

  task automatic test_count_123();
    logic [7:0] exp [4];
    bit ok;
    exp = '{8'hB0, 8'h24, 8'hF9, 8'h83};
    @(posedge clk); #1;
    bus.cnt_dis = 9'd123;
    bus.win = 1'b1;
    wait_show(3, 8'h83, 60, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL c123_latency: got %0d required 1", ok); end
    capture_frame();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL c123_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
      n_checks++;
      if (cap_lit[j] !== 4) begin n_fail++; $display("FAIL c123_lit%0d: got %0d required 4", j, cap_lit[j]); end
    end
  endtask

  task automatic test_max_511();
    logic [7:0] exp [4];
    logic [11:0] prev, cur;
    bit ok;
    bit seen;
    exp = '{8'hF9, 8'h79, 8'h92, 8'h88};
    prev = dut.u_b2b.bcd_o;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.cnt_dis = 9'd511;
    bus.win = 1'b0;
    // The first observed change of the digit registers must already be the full result
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cur = dut.u_b2b.bcd_o;
      if (cur != prev) begin
        seen = 1'b1;
        n_checks++;
        if (cur !== 12'h511) begin n_fail++; $display("FAIL m511_atomic: got %h required %h", cur, 12'h511); end
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL m511_update: got %0d required 1", seen); end
    wait_show(3, 8'h88, 40, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL m511_show: got %0d required 1", ok); end
    capture_frame();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL m511_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
    end
  endtask

  task automatic test_stability_filter();
    logic [7:0] hold [4];
    logic [7:0] exp [4];
    logic [3:0] m;
    int bad;
    bit ok;
    hold = '{8'hF9, 8'h79, 8'h92, 8'h88};
    exp  = '{8'hC0, 8'h40, 8'hF9, 8'h88};
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      bus.cnt_dis = (i % 2 == 0) ? 9'd99 : 9'd100;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        m = ~(4'b0001 << j);
        if (bus.an == m && bus.seg != hold[j]) bad++;
      end
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL filt_display_changed: got %0d bad cycles required 0", bad); end
    n_checks++;
    if (dut.u_b2b.bcd_o !== 12'h511) begin n_fail++; $display("FAIL filt_bcd: got %h required %h", dut.u_b2b.bcd_o, 12'h511); end
    @(posedge clk); #1;
    bus.cnt_dis = 9'd100;
    wait_show(0, 8'hC0, 80, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL filt_hold_show: got %0d required 1", ok); end
    capture_frame();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL filt_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
    end
  endtask

  task automatic test_freeze_blink();
    logic [7:0] exp [4];
    logic [3:0] m;
    int runs [16];
    bit run_dark [16];
    int nruns, run_len, bad;
    bit cur_dark, prev_dark;
    exp = '{8'hC0, 8'h40, 8'hF9, 8'h88};
    nruns = 0;
    run_len = 0;
    bad = 0;
    prev_dark = 1'b0;
    @(posedge clk); #1;
    bus.seg_en = 1'b1;
    bus.cnt_dis = 9'd101;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 50) bus.cnt_dis = 9'd102;
      cur_dark = (bus.an == 4'hF);
      for (int j = 0; j < 4; j++) begin
        m = ~(4'b0001 << j);
        if (bus.an == m && bus.seg != exp[j]) bad++;
      end
      if (i == 0 || cur_dark == prev_dark) begin
        run_len++;
      end else begin
        if (nruns < 16) begin
          runs[nruns] = run_len;
          run_dark[nruns] = prev_dark;
        end
        nruns++;
        run_len = 1;
      end
      prev_dark = cur_dark;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL frz_display_changed: got %0d bad cycles required 0", bad); end
    n_checks++;
    if (nruns < 4) begin n_fail++; $display("FAIL frz_run_count: got %0d required >=4", nruns); end
    else begin
      n_checks++;
      if (run_dark[1] !== 1'b1) begin n_fail++; $display("FAIL frz_first_off: got %0d required 1", run_dark[1]); end
      for (int r = 1; r < 4; r++) begin
        n_checks++;
        if (runs[r] !== 32) begin n_fail++; $display("FAIL frz_run%0d_len: got %0d required 32", r, runs[r]); end
      end
    end
  endtask

  task automatic test_unfreeze();
    logic [7:0] exp [4];
    bit ok;
    exp = '{8'hA4, 8'h40, 8'hF9, 8'h88};
    @(posedge clk); #1;
    bus.seg_en = 1'b0;
    wait_show(0, 8'hA4, 80, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL unfrz_track: got %0d required 1", ok); end
    capture_frame();
    n_checks++;
    if (cap_dark !== 0) begin n_fail++; $display("FAIL unfrz_blink_stopped: got %0d dark cycles required 0", cap_dark); end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL unfrz_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] exp [4];
    bit ok;
    bit found;
    exp = '{8'hA4, 8'h40, 8'hF9, 8'h88};
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.u_b2b.state_q == ST_SHIFT) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rms_find_shift: got %0d required 1", found); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.u_b2b.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rms_fsm_idle: got %0d required %0d", dut.u_b2b.state_q, ST_IDLE); end
    n_checks++;
    if (bus.seg !== 8'hFF) begin n_fail++; $display("FAIL rms_seg: got %h required %h", bus.seg, 8'hFF); end
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL rms_an: got %h required %h", bus.an, 4'hF); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL rms_dark_until_done: got %h required %h", bus.an, 4'hF); end
    wait_show(0, 8'hA4, 80, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rms_resume: got %0d required 1", ok); end
    capture_frame();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cap_seg[j] !== exp[j]) begin n_fail++; $display("FAIL rms_digit%0d: got %h required %h", j, cap_seg[j], exp[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_count_123();
    test_max_511();
    test_stability_filter();
    test_freeze_blink();
    test_unfreeze();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
